// File: rtl/ref_dac_pkg.sv
// Shared types, default parameters and constant helpers for the reference DAC loader.
package ref_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int N_CH_DEF    = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int CLK_DIV_DEF = 4;

    // Minimum width of 1 so a single-bit index is still a legal vector.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ref_sclk_gen.sv
// SCLK generator: half-period down-counter, idles low and restarts from a low phase
// whenever en rises.
module ref_sclk_gen
    import ref_dac_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] HALF_LD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    // Ticks flag the last cycle of a half-period, i.e. sclk toggles on the next edge.
    always_comb begin
        cnt_d     = HALF_LD;
        sclk_d    = 1'b0;
        rise_tick = 1'b0;
        fall_tick = 1'b0;
        if (en) begin
            if (cnt_q == 8'd0) begin
                sclk_d    = ~sclk_q;
                rise_tick = ~sclk_q;
                fall_tick = sclk_q;
            end else begin
                cnt_d  = cnt_q - 8'd1;
                sclk_d = sclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/ref_dac_loader.sv
// Serial loader for N_CH reference DACs on a shared SDI/SCLK bus, with per-channel
// chip-selects and mux lines that update atomically at the end of each load.
//   state | meaning
//   IDLE  | waiting for start; only state that accepts a request
//   SHIFT | DATA_W bits out MSB first, CS low
//   HOLD  | CLK_DIV cycles, CS still low, sclk low
//   GAP   | CLK_DIV cycles, CS high
//   DONE  | one cycle, done pulse, mux update
module ref_dac_loader
    import ref_dac_pkg::*;
#(
    parameter int  N_CH    = N_CH_DEF,
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  CLK_DIV = CLK_DIV_DEF,
    localparam int CH_W    = clog2_f(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bcast,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [DATA_W-1:0] data,
    input  logic              mux_upd,
    input  logic              mux_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sdi,
    output logic              sclk,
    output logic [N_CH-1:0]   cs_n,
    output logic [N_CH-1:0]   mux
);

    localparam int                BITS_W  = clog2_f(DATA_W + 1);
    localparam logic [BITS_W-1:0] BITS_LD = BITS_W'(DATA_W);
    localparam logic [7:0]        HALF_LD = 8'(CLK_DIV - 1);
    localparam logic [CH_W:0]     N_CH_L  = (CH_W + 1)'(N_CH);

    state_e              state_q, state_d;
    logic [DATA_W-2:0]   sh_q, sh_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic [7:0]          tmr_q, tmr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                bcast_q, bcast_d;
    logic                mux_upd_q, mux_upd_d;
    logic                mux_val_q, mux_val_d;
    logic [N_CH-1:0]     cs_n_q, cs_n_d;
    logic [N_CH-1:0]     mux_q, mux_d;
    logic                sdi_q, sdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [N_CH-1:0]     sel_in, sel_cur;
    logic                rise_tick, fall_tick;

    ref_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == ST_SHIFT),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bits_d    = bits_q;
        tmr_d     = tmr_q;
        ch_d      = ch_q;
        bcast_d   = bcast_q;
        mux_upd_d = mux_upd_q;
        mux_val_d = mux_val_q;
        cs_n_d    = cs_n_q;
        mux_d     = mux_q;
        sdi_d     = sdi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sel_in    = '0;
        sel_cur   = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_in[i]  = bcast | (ch_sel == CH_W'(i));
            sel_cur[i] = bcast_q | (ch_q == CH_W'(i));
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (bcast || ({1'b0, ch_sel} < N_CH_L)) begin
                        state_d   = ST_SHIFT;
                        sh_d      = data[DATA_W-2:0];
                        sdi_d     = data[DATA_W-1];
                        bits_d    = BITS_LD;
                        ch_d      = ch_sel;
                        bcast_d   = bcast;
                        mux_upd_d = mux_upd;
                        mux_val_d = mux_val;
                        cs_n_d    = ~sel_in;
                        busy_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (rise_tick) bits_d = bits_q - 1'b1;
                // The fall after the last sampled bit ends the word instead of shifting.
                if (fall_tick) begin
                    if (bits_q == '0) begin
                        state_d = ST_HOLD;
                        tmr_d   = HALF_LD;
                        sdi_d   = 1'b0;
                    end else begin
                        sdi_d = sh_q[DATA_W-2];
                        sh_d  = {sh_q[DATA_W-3:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_q == 8'd0) begin
                    state_d = ST_GAP;
                    tmr_d   = HALF_LD;
                    cs_n_d  = '1;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (tmr_q == 8'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (mux_upd_q)
                        mux_d = (mux_q & ~sel_cur) | (sel_cur & {N_CH{mux_val_q}});
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            bits_q    <= '0;
            tmr_q     <= '0;
            ch_q      <= '0;
            bcast_q   <= 1'b0;
            mux_upd_q <= 1'b0;
            mux_val_q <= 1'b0;
            cs_n_q    <= '1;
            mux_q     <= '0;
            sdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bits_q    <= bits_d;
            tmr_q     <= tmr_d;
            ch_q      <= ch_d;
            bcast_q   <= bcast_d;
            mux_upd_q <= mux_upd_d;
            mux_val_q <= mux_val_d;
            cs_n_q    <= cs_n_d;
            mux_q     <= mux_d;
            sdi_q     <= sdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cs_n = cs_n_q;
    assign mux  = mux_q;
    assign sdi  = sdi_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ref_dac_loader.sv
// Directed bench for ref_dac_loader: default build, a 5-channel build for the
// illegal-select path, and an 8-bit CLK_DIV=1 build for back-to-back loads.
module tb_ref_dac_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        d_start, d_bcast, d_mux_upd, d_mux_val;
    logic [1:0]  d_ch;
    logic [15:0] d_data;
    logic        d_busy, d_done, d_err, d_sdi, d_sclk;
    logic [3:0]  d_cs_n, d_mux;

    logic        e_start, e_bcast, e_mux_upd, e_mux_val;
    logic [2:0]  e_ch;
    logic [15:0] e_data;
    logic        e_busy, e_done, e_err, e_sdi, e_sclk;
    logic [4:0]  e_cs_n, e_mux;

    logic        f_start, f_bcast, f_mux_upd, f_mux_val;
    logic [1:0]  f_ch;
    logic [7:0]  f_data;
    logic        f_busy, f_done, f_err, f_sdi, f_sclk;
    logic [3:0]  f_cs_n, f_mux;

    int n_checks = 0;
    int n_errors = 0;

    ref_dac_loader u_dut (
        .clk(clk), .rst_n(rst_n), .start(d_start), .bcast(d_bcast), .ch_sel(d_ch),
        .data(d_data), .mux_upd(d_mux_upd), .mux_val(d_mux_val), .busy(d_busy),
        .done(d_done), .err(d_err), .sdi(d_sdi), .sclk(d_sclk), .cs_n(d_cs_n), .mux(d_mux)
    );

    ref_dac_loader #(.N_CH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(e_start), .bcast(e_bcast), .ch_sel(e_ch),
        .data(e_data), .mux_upd(e_mux_upd), .mux_val(e_mux_val), .busy(e_busy),
        .done(e_done), .err(e_err), .sdi(e_sdi), .sclk(e_sclk), .cs_n(e_cs_n), .mux(e_mux)
    );

    ref_dac_loader #(.N_CH(4), .DATA_W(8), .CLK_DIV(1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .start(f_start), .bcast(f_bcast), .ch_sel(f_ch),
        .data(f_data), .mux_upd(f_mux_upd), .mux_val(f_mux_val), .busy(f_busy),
        .done(f_done), .err(f_err), .sdi(f_sdi), .sclk(f_sclk), .cs_n(f_cs_n), .mux(f_mux)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the most recent load0 run
    int          r_cs_low, r_cs_bad, r_rises, r_done_cnt, r_done_k, r_busy_bad, r_err, r_mux_chg;
    logic [15:0] r_word;
    logic [3:0]  r_mux_done, r_mux_pre;

    // One load on the default build; accept cycle is k=0, observations at k=1..200.
    task automatic load0(input logic [1:0] ch, input logic bc, input logic [15:0] dat,
                         input logic mu, input logic mv, input int pulse_k);
        logic [3:0] exp_mask;
        logic [3:0] prev_mux;
        logic       prev_sclk;
        exp_mask = bc ? 4'b0000 : ~(4'b0001 << ch);
        r_cs_low = 0; r_cs_bad = 0; r_rises = 0; r_done_cnt = 0; r_done_k = -1;
        r_busy_bad = 0; r_err = 0; r_mux_chg = 0; r_word = '0;
        r_mux_done = 'x; r_mux_pre = 'x;
        @(negedge clk);
        d_ch = ch; d_bcast = bc; d_data = dat; d_mux_upd = mu; d_mux_val = mv; d_start = 1'b1;
        prev_mux  = d_mux;
        prev_sclk = 1'b0;
        @(posedge clk);
        #1 d_start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (d_cs_n != 4'hF) r_cs_low++;
            if (d_cs_n != 4'hF && d_cs_n != exp_mask) r_cs_bad++;
            if (!prev_sclk && d_sclk) begin
                r_rises++;
                r_word = {r_word[14:0], d_sdi};
            end
            prev_sclk = d_sclk;
            if (d_done) begin
                r_done_cnt++;
                if (r_done_cnt == 1) begin
                    r_done_k   = k;
                    r_mux_done = d_mux;
                    r_mux_pre  = prev_mux;
                end
            end
            if (d_cs_n != 4'hF && d_mux != prev_mux) r_mux_chg++;
            prev_mux = d_mux;
            if (d_busy !== (k < 137)) r_busy_bad++;
            if (d_err) r_err++;
            if (k == pulse_k) begin
                d_start = 1'b1; d_ch = 2'd1; d_data = 16'hFFFF;
            end else begin
                d_start = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e_errs, e_busy_n, e_cs_act, e_sclk_n, e_err_k;
        int f_nd, f_dk[3], f_runs[2], f_nrun, f_hi, f_sclk_bad, f_cs_bad, f_rises;
        logic f_prev_low, f_prev_sclk;
        logic [7:0] f_word;

        d_start = 0; d_bcast = 0; d_ch = 0; d_data = 0; d_mux_upd = 0; d_mux_val = 0;
        e_start = 0; e_bcast = 0; e_ch = 0; e_data = 0; e_mux_upd = 0; e_mux_val = 0;
        f_start = 0; f_bcast = 0; f_ch = 0; f_data = 0; f_mux_upd = 0; f_mux_val = 0;

        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(d_cs_n), 32'hF);
        check("rst_sclk", 32'(d_sclk), 0);
        check("rst_sdi",  32'(d_sdi), 0);
        check("rst_mux",  32'(d_mux), 0);
        check("rst_busy", 32'(d_busy), 0);
        check("rst_done", 32'(d_done), 0);
        check("rst_err",  32'(d_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single channel 2, A5C3, no mux update
        load0(2'd2, 1'b0, 16'hA5C3, 1'b0, 1'b0, 0);
        check("t1_cs_low_cycles", r_cs_low, 132);
        check("t1_cs_wrong_ch",   r_cs_bad, 0);
        check("t1_rises",         r_rises, 16);
        check("t1_word",          32'(r_word), 32'hA5C3);
        check("t1_done_latency",  r_done_k, 137);
        check("t1_done_count",    r_done_cnt, 1);
        check("t1_mux",           32'(r_mux_done), 0);
        check("t1_busy_profile",  r_busy_bad, 0);
        check("t1_err",           r_err, 0);

        // Broadcast with mux update
        load0(2'd0, 1'b1, 16'h8001, 1'b1, 1'b1, 0);
        check("t2_cs_low_cycles", r_cs_low, 132);
        check("t2_cs_not_all",    r_cs_bad, 0);
        check("t2_word",          32'(r_word), 32'h8001);
        check("t2_done_latency",  r_done_k, 137);
        check("t2_mux_before",    32'(r_mux_pre), 32'h0);
        check("t2_mux_at_done",   32'(r_mux_done), 32'hF);
        check("t2_mux_chg_cs_lo", r_mux_chg, 0);

        // Start pulsed mid-load is ignored
        load0(2'd3, 1'b0, 16'h0F0F, 1'b0, 1'b0, 40);
        check("t3_done_count",    r_done_cnt, 1);
        check("t3_rises",         r_rises, 16);
        check("t3_word",          32'(r_word), 32'h0F0F);
        check("t3_cs_wrong_ch",   r_cs_bad, 0);
        check("t3_err",           r_err, 0);
        check("t3_mux_kept",      32'(r_mux_done), 32'hF);

        // Async reset at cycle 60 of a load
        @(negedge clk);
        d_ch = 2'd3; d_bcast = 0; d_data = 16'hFFFF; d_mux_upd = 0; d_start = 1'b1;
        @(posedge clk);
        #1 d_start = 1'b0;
        repeat (60) @(negedge clk);
        check("t4_cs_before_rst",  32'(d_cs_n), 32'h7);
        check("t4_mux_before_rst", 32'(d_mux), 32'hF);
        rst_n = 1'b0;
        #1;
        check("t4_rst_cs_n", 32'(d_cs_n), 32'hF);
        check("t4_rst_sclk", 32'(d_sclk), 0);
        check("t4_rst_sdi",  32'(d_sdi), 0);
        check("t4_rst_mux",  32'(d_mux), 0);
        check("t4_rst_busy", 32'(d_busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load0(2'd0, 1'b0, 16'h1234, 1'b1, 1'b1, 0);
        check("t4_post_word",    32'(r_word), 32'h1234);
        check("t4_post_latency", r_done_k, 137);
        check("t4_post_cs_low",  r_cs_low, 132);
        check("t4_post_mux",     32'(r_mux_done), 32'h1);

        // Illegal channel on a 5-channel build
        e_errs = 0; e_busy_n = 0; e_cs_act = 0; e_sclk_n = 0; e_err_k = -1;
        @(negedge clk);
        e_ch = 3'd5; e_bcast = 0; e_data = 16'hFFFF; e_start = 1'b1;
        @(posedge clk);
        #1 e_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (e_err) begin e_errs++; e_err_k = k; end
            if (e_busy) e_busy_n++;
            if (e_cs_n != 5'h1F) e_cs_act++;
            if (e_sclk) e_sclk_n++;
        end
        check("t5_err_pulses", e_errs, 1);
        check("t5_err_cycle",  e_err_k, 1);
        check("t5_busy",       e_busy_n, 0);
        check("t5_cs_idle",    e_cs_act, 0);
        check("t5_sclk_idle",  e_sclk_n, 0);
        @(negedge clk);
        e_ch = 3'd4; e_start = 1'b1;
        @(posedge clk);
        #1 e_start = 1'b0;
        @(negedge clk);
        check("t5_ch4_busy", 32'(e_busy), 1);
        check("t5_ch4_cs_n", 32'(e_cs_n), 32'h0F);
        check("t5_ch4_err",  32'(e_err), 0);

        // Back-to-back on the CLK_DIV=1, 8-bit build
        f_nd = 0; f_nrun = 0; f_hi = 0; f_sclk_bad = 0; f_cs_bad = 0; f_rises = 0;
        f_dk = '{-1, -1, -1}; f_runs = '{-1, -1};
        f_prev_low = 1'b1; f_prev_sclk = 1'b0; f_word = '0;
        @(negedge clk);
        f_ch = 2'd3; f_data = 8'h96; f_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 62; k++) begin
            @(negedge clk);
            if (f_done) begin
                if (f_nd < 3) f_dk[f_nd] = k;
                f_nd++;
            end
            if (f_cs_n != 4'hF) begin
                if (f_cs_n != 4'h7) f_cs_bad++;
                if (!f_prev_low) begin
                    if (f_nrun < 2) f_runs[f_nrun] = f_hi;
                    f_nrun++;
                end
                f_hi = 0;
                f_prev_low = 1'b1;
            end else begin
                f_hi++;
                f_prev_low = 1'b0;
            end
            if (k <= 16 && f_sclk !== ((k % 2) == 0)) f_sclk_bad++;
            if (k <= 17 && !f_prev_sclk && f_sclk) begin
                f_rises++;
                f_word = {f_word[6:0], f_sdi};
            end
            f_prev_sclk = f_sclk;
        end
        f_start = 1'b0;
        check("t6_done_count",  f_nd, 3);
        check("t6_done1_lat",   f_dk[0], 19);
        check("t6_done2_lat",   f_dk[1] - f_dk[0], 20);
        check("t6_done3_lat",   f_dk[2] - f_dk[1], 20);
        check("t6_cs_high_1",   f_runs[0], 3);
        check("t6_cs_high_2",   f_runs[1], 3);
        check("t6_sclk_div2",   f_sclk_bad, 0);
        check("t6_rises",       f_rises, 8);
        check("t6_word",        32'(f_word), 32'h96);
        check("t6_cs_wrong_ch", f_cs_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
